// File: rtl/draw_bg_scroll_if.sv
// Shared VGA geometry package and the timing+rgb bundle interface
// used between stages of the video pipeline.
package vga_pkg;
  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;
endpackage

interface vga_if;
  logic [10:0] vcount;
  logic [10:0] hcount;
  logic        vsync;
  logic        vblnk;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in (
    input vcount, hcount, vsync, vblnk,
    input hsync, hblnk, rgb
  );
  modport out (
    output vcount, hcount, vsync, vblnk,
    output hsync, hblnk, rgb
  );
endinterface

// File: rtl/draw_bg_scroll.sv
// Background stage: coloured frame edges, scrolling checkerboard
// fill and pass-through of non-key upstream pixels, 2-cycle latency.
module draw_bg_scroll
  import vga_pkg::*;
#(
  parameter int          BORDER_W     = 1,
  parameter int          TILE_LOG2    = 5,
  parameter int          FRAME_DIV    = 1,
  parameter int          SCROLL_STEP  = 1,
  parameter logic [11:0] KEY_COLOR    = 12'h000,
  parameter logic [11:0] COLOR_TOP    = 12'hff0,
  parameter logic [11:0] COLOR_BOTTOM = 12'hf00,
  parameter logic [11:0] COLOR_LEFT   = 12'h0f0,
  parameter logic [11:0] COLOR_RIGHT  = 12'h00f,
  parameter logic [11:0] COLOR_A      = 12'h452,
  parameter logic [11:0] COLOR_B      = 12'h342
) (
  input  logic clk,
  input  logic rst,
  vga_if.in    in,
  vga_if.out   out,
  input  logic scroll_en,
  input  logic scroll_dir,
  output logic frame_tick
);

  localparam int OW = TILE_LOG2 + 1;
  localparam logic [10:0] BW = 11'(BORDER_W);
  localparam logic [10:0] VB = 11'(VER_PIXELS - BORDER_W);
  localparam logic [10:0] HB = 11'(HOR_PIXELS - BORDER_W);
  localparam logic [OW-1:0] STEP = OW'(SCROLL_STEP);
  localparam logic [7:0] DIV_MAX = 8'(FRAME_DIV - 1);

  typedef enum logic [2:0] {
    R_BLANK, R_TOP, R_BOTTOM, R_LEFT,
    R_RIGHT, R_PASS, R_TILE_A, R_TILE_B
  } region_t;

  logic          vblnk_q;
  logic [7:0]    div_cnt;
  logic [OW-1:0] off;
  logic          rise;

  assign rise = in.vblnk & ~vblnk_q;

  // offset only moves on vblank entry, so it is stable over active lines
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q    <= 1'b0;
      frame_tick <= 1'b0;
      div_cnt    <= 8'd0;
      off        <= '0;
    end else begin
      vblnk_q    <= in.vblnk;
      frame_tick <= rise;
      if (rise && scroll_en) begin
        if (div_cnt == DIV_MAX) begin
          div_cnt <= 8'd0;
          off <= scroll_dir ? off - STEP
                            : off + STEP;
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
      end
    end
  end

  logic [OW-1:0] y;
  logic          par;
  region_t       code_d;

  assign y   = in.vcount[OW-1:0] + off;
  assign par = y[TILE_LOG2] ^ in.hcount[TILE_LOG2];

  always_comb begin
    code_d = R_BLANK;
    if (in.vblnk | in.hblnk)  code_d = R_BLANK;
    else if (in.vcount < BW)  code_d = R_TOP;
    else if (in.vcount >= VB) code_d = R_BOTTOM;
    else if (in.hcount < BW)  code_d = R_LEFT;
    else if (in.hcount >= HB) code_d = R_RIGHT;
    else if (in.rgb != KEY_COLOR)
      code_d = R_PASS;
    else
      code_d = par ? R_TILE_B : R_TILE_A;
  end

  logic [10:0] vc1, hc1;
  logic        vs1, vb1, hs1, hb1;
  logic [11:0] rgb1;
  region_t     code_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vc1    <= '0;
      hc1    <= '0;
      vs1    <= 1'b0;
      vb1    <= 1'b0;
      hs1    <= 1'b0;
      hb1    <= 1'b0;
      rgb1   <= '0;
      code_q <= R_BLANK;
    end else begin
      vc1    <= in.vcount;
      hc1    <= in.hcount;
      vs1    <= in.vsync;
      vb1    <= in.vblnk;
      hs1    <= in.hsync;
      hb1    <= in.hblnk;
      rgb1   <= in.rgb;
      code_q <= code_d;
    end
  end

  logic [11:0] rgb_d;

  always_comb begin
    rgb_d = 12'h000;
    unique case (code_q)
      R_BLANK:  rgb_d = 12'h000;
      R_TOP:    rgb_d = COLOR_TOP;
      R_BOTTOM: rgb_d = COLOR_BOTTOM;
      R_LEFT:   rgb_d = COLOR_LEFT;
      R_RIGHT:  rgb_d = COLOR_RIGHT;
      R_PASS:   rgb_d = rgb1;
      R_TILE_A: rgb_d = COLOR_A;
      R_TILE_B: rgb_d = COLOR_B;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out.vcount <= '0;
      out.hcount <= '0;
      out.vsync  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.hsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      out.vcount <= vc1;
      out.hcount <= hc1;
      out.vsync  <= vs1;
      out.vblnk  <= vb1;
      out.hsync  <= hs1;
      out.hblnk  <= hb1;
      out.rgb    <= rgb_d;
    end
  end

endmodule

// File: tb/tb_draw_bg_scroll.sv
// Directed bench for draw_bg_scroll: region table, latency,
// reset, scroll divider, hold and offset wrap.
module tb_draw_bg_scroll;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic dir = 1'b0;
  logic en2 = 1'b0;
  logic tick, tick2;

  vga_if in_if ();
  vga_if out_if ();
  vga_if out2_if ();

  always #5 clk = ~clk;

  draw_bg_scroll #(
    .BORDER_W(4), .TILE_LOG2(5),
    .FRAME_DIV(2), .SCROLL_STEP(4)
  ) dut (
    .clk(clk), .rst(rst),
    .in(in_if), .out(out_if),
    .scroll_en(en), .scroll_dir(dir),
    .frame_tick(tick)
  );

  draw_bg_scroll #(
    .BORDER_W(4), .TILE_LOG2(5),
    .FRAME_DIV(1), .SCROLL_STEP(32)
  ) dut2 (
    .clk(clk), .rst(rst),
    .in(in_if), .out(out2_if),
    .scroll_en(en2), .scroll_dir(1'b0),
    .frame_tick(tick2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [5:0] m_off = '0;
  int m_div = 0;

  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    logic        vb;
    logic        hb;
    logic [11:0] rgb;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic pix(input logic [10:0] h, input logic [10:0] v,
                     input logic [11:0] rgb);
    in_if.hcount = h;
    in_if.vcount = v;
    in_if.rgb    = rgb;
    in_if.vblnk  = 1'b0;
    in_if.hblnk  = 1'b0;
  endtask

  task automatic frame();
    in_if.vblnk = 1'b1;
    step();
    chk("tick_hi", int'(tick), 1);
    chk("tick2_hi", int'(tick2), 1);
    if (en) begin
      if (m_div == 1) begin
        m_div = 0;
        m_off = dir ? m_off - 6'd4 : m_off + 6'd4;
      end else begin
        m_div = m_div + 1;
      end
    end
    chk("off", int'(dut.off), int'(m_off));
    chk("div", int'(dut.div_cnt), m_div);
    step();
    chk("tick_lo", int'(tick), 0);
    in_if.vblnk = 1'b0;
    step();
  endtask

  initial begin
    vecs[0]  = '{11'd2,   11'd10,  1'b0, 1'b0, 12'h000, 12'h0f0};
    vecs[1]  = '{11'd799, 11'd0,   1'b0, 1'b0, 12'h000, 12'hff0};
    vecs[2]  = '{11'd100, 11'd596, 1'b0, 1'b0, 12'h000, 12'hf00};
    vecs[3]  = '{11'd797, 11'd100, 1'b0, 1'b0, 12'h000, 12'h00f};
    vecs[4]  = '{11'd100, 11'd100, 1'b1, 1'b0, 12'h000, 12'h000};
    vecs[5]  = '{11'd100, 11'd100, 1'b0, 1'b1, 12'habc, 12'h000};
    vecs[6]  = '{11'd100, 11'd100, 1'b0, 1'b0, 12'habc, 12'habc};
    vecs[7]  = '{11'd4,   11'd40,  1'b0, 1'b0, 12'h000, 12'h342};
    vecs[8]  = '{11'd31,  11'd40,  1'b0, 1'b0, 12'h000, 12'h342};
    vecs[9]  = '{11'd40,  11'd40,  1'b0, 1'b0, 12'h000, 12'h452};
    vecs[10] = '{11'd2,   11'd10,  1'b0, 1'b0, 12'habc, 12'h0f0};
    vecs[11] = '{11'd3,   11'd3,   1'b0, 1'b0, 12'h000, 12'hff0};
    vecs[12] = '{11'd4,   11'd4,   1'b0, 1'b0, 12'h000, 12'h452};

    // reset held with activity on the input bundle
    rst = 1'b1;
    in_if.hcount = 11'd5;
    in_if.vcount = 11'd7;
    in_if.vsync  = 1'b1;
    in_if.hsync  = 1'b1;
    in_if.vblnk  = 1'b1;
    in_if.hblnk  = 1'b1;
    in_if.rgb    = 12'habc;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_rgb", int'(out_if.rgb), 0);
      chk("rst_h", int'(out_if.hcount), 0);
      chk("rst_vb", int'(out_if.vblnk), 0);
      chk("rst_tick", int'(tick), 0);
    end
    rst = 1'b0;
    step();
    chk("rel_tick", int'(tick), 1);
    chk("rel_out0", int'(out_if.vblnk), 0);
    step();
    chk("rel_tick_lo", int'(tick), 0);
    chk("rel_out_vb", int'(out_if.vblnk), 1);
    chk("rel_out_h", int'(out_if.hcount), 5);
    chk("rel_out_vs", int'(out_if.vsync), 1);
    in_if.vblnk = 1'b0;
    in_if.hblnk = 1'b0;
    step();

    for (int i = 0; i < 13; i++) begin
      pix(vecs[i].h, vecs[i].v, vecs[i].rgb);
      in_if.vblnk = vecs[i].vb;
      in_if.hblnk = vecs[i].hb;
      step();
      step();
      chk($sformatf("vec%0d", i), int'(out_if.rgb), int'(vecs[i].exp));
    end
    in_if.vblnk = 1'b0;
    in_if.hblnk = 1'b0;
    step();

    // per-cycle changing input: outputs trail by exactly two clocks
    for (int i = 0; i < 6; i++) begin
      in_if.hcount = 11'(200 + i);
      in_if.vcount = 11'(300 + i);
      in_if.hsync  = i[0];
      step();
      if (i >= 1) begin
        chk("lat_h", int'(out_if.hcount), 200 + i - 1);
        chk("lat_v", int'(out_if.vcount), 300 + i - 1);
        chk("lat_hs", int'(out_if.hsync), (i - 1) % 2);
      end
    end

    en = 1'b1;
    dir = 1'b0;
    for (int f = 0; f < 5; f++) frame();
    chk("off_after5", int'(dut.off), 8);

    en = 1'b0;
    for (int f = 0; f < 3; f++) frame();
    chk("hold_off", int'(dut.off), 8);
    chk("hold_div", int'(dut.div_cnt), 1);

    en = 1'b1;
    dir = 1'b1;
    for (int f = 0; f < 5; f++) frame();
    chk("wrap_down", int'(dut.off), 60);

    en = 1'b0;
    en2 = 1'b1;
    pix(11'd40, 11'd40, 12'h000);
    step();
    step();
    chk("ph0", int'(out2_if.rgb), 12'h452);
    frame();
    chk("off2_32", int'(dut2.off), 32);
    step();
    step();
    chk("ph_inv", int'(out2_if.rgb), 12'h342);
    frame();
    chk("off2_0", int'(dut2.off), 0);
    step();
    step();
    chk("ph_rest", int'(out2_if.rgb), 12'h452);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
